// File: rtl/key_pkg.sv
// Shared definitions for the multi-channel key debouncer: channel state
// encoding, default timing for the 5 ms scan clock, and a parameter sanity helper.
package key_pkg;

    // Per-channel debounce state, fixed 2-bit encoding
    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } key_state_e;

    // Default timing in scan-clock samples (5 ms per sample)
    localparam int DEF_N_KEYS       = 4;
    localparam int DEF_DURATION     = 10;   // 50 ms debounce
    localparam int DEF_LONG_TICKS   = 200;  // 1 s long press
    localparam int DEF_REPEAT_TICKS = 40;   // 200 ms auto-repeat
    localparam int DEF_ACTIVE_HIGH  = 1;

    // True when a parameter set is legal for the debouncer
    function automatic bit params_ok(input int n_keys, input int duration,
                                     input int long_ticks, input int repeat_ticks);
        return (n_keys >= 1) && (duration >= 1) &&
               (long_ticks > duration) && (repeat_ticks >= 1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One debounced key channel: press/release filter FSM, hold timer with a
// single long-press pulse and, with KEY_DEBOUNCE_MULTI_REPEAT_EN defined,
// auto-repeat press pulses after the long press. Input is already normalised
// (1 = pressed). All outputs are registered.
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int DURATION     = DEF_DURATION,
    parameter int LONG_TICKS   = DEF_LONG_TICKS
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
    ,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
`endif
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic k_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int CW = $clog2(DURATION + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [CW-1:0] DUR_C  = CW'(DURATION);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [HW-1:0] LONG_C = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HONE_C = HW'(1);
    localparam bit SINGLE = (DURATION == 1);

`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_LAST_C = RW'(REPEAT_TICKS - 1);
    logic [RW-1:0] rep_q, rep_d;
`endif

    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    // Next-state, counter and event logic; pulses default low every cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
        rep_d     = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (k_i) begin
                    if (SINGLE) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        cnt_d   = '0;
                        hold_d  = '0;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = ONE_C;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (k_i) begin
                    if (cnt_q + ONE_C == DUR_C) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        cnt_d   = '0;
                        hold_d  = '0;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end else begin
                    // glitch shorter than DURATION: drop it silently
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                if (k_i) begin
                    cnt_d = '0;
                    if (hold_q != LONG_C) begin
                        hold_d = hold_q + HONE_C;
                        if (hold_q == LONG_C - HONE_C) begin
                            long_d = 1'b1;
                        end else begin
                            long_d = 1'b0;
                        end
                    end else begin
                        // hold saturated: long press already reported
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
                        if (rep_q == REP_LAST_C) begin
                            press_d = 1'b1;
                            rep_d   = '0;
                        end else begin
                            rep_d = rep_q + RW'(1);
                        end
`else
                        hold_d = hold_q;
`endif
                    end
                end else begin
                    if (SINGLE) begin
                        state_d   = IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        cnt_d     = '0;
                        hold_d    = '0;
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
                        rep_d     = '0;
`endif
                    end else begin
                        // hold and repeat timers freeze while release is pending
                        state_d = RELEASE_WAIT;
                        cnt_d   = ONE_C;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (k_i) begin
                    // bounce during release: back to HELD, timers resume
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q + ONE_C == DUR_C) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                    hold_d    = '0;
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
                    rep_d     = '0;
`endif
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                hold_d  = '0;
                level_d = 1'b0;
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
                rep_d   = '0;
`endif
            end
        endcase
    end

    // State, counter and output registers with immediate asynchronous clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer and event generator. Normalises key polarity
// and runs one independent key_debounce_channel per key.
// Optional macro KEY_DEBOUNCE_MULTI_REPEAT_EN enables auto-repeat press pulses.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int N_KEYS       = DEF_N_KEYS,
    parameter int DURATION     = DEF_DURATION,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int ACTIVE_HIGH  = DEF_ACTIVE_HIGH,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [N_KEYS-1:0] key_i,
    output logic [N_KEYS-1:0] level_o,
    output logic [N_KEYS-1:0] press_o,
    output logic [N_KEYS-1:0] release_o,
    output logic [N_KEYS-1:0] long_o
);

    localparam bit PARAMS_OK = params_ok(N_KEYS, DURATION, LONG_TICKS, REPEAT_TICKS);

    logic [N_KEYS-1:0] k_s;

    // Polarity mux: k_s is 1 whenever the key is pressed
    always_comb begin
        if (ACTIVE_HIGH != 0) begin
            k_s = key_i;
        end else begin
            k_s = ~key_i;
        end
    end

    // An illegal parameter set shows up as this named scope in the hierarchy
    if (!PARAMS_OK) begin : g_illegal_parameters
    end

    for (genvar n = 0; n < N_KEYS; n++) begin : g_ch
        key_debounce_channel #(
            .DURATION     (DURATION),
            .LONG_TICKS   (LONG_TICKS)
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
            ,
            .REPEAT_TICKS (REPEAT_TICKS)
`endif
        ) u_ch (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .k_i       (k_s[n]),
            .level_o   (level_o[n]),
            .press_o   (press_o[n]),
            .release_o (release_o[n]),
            .long_o    (long_o[n])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: one active-high and one active-low
// instance (N_KEYS=4, DURATION=10, LONG_TICKS=200, REPEAT_TICKS=40).
// Repeat expectations follow KEY_DEBOUNCE_MULTI_REPEAT_EN.
module tb_key_debounce_multi;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_a, key_b;
    logic [3:0] level_a, press_a, release_a, long_a;
    logic [3:0] level_b, press_b, release_b, long_b;
    int         checks;
    int         errors;

    key_debounce_multi #(
        .N_KEYS(4), .DURATION(10), .LONG_TICKS(200), .ACTIVE_HIGH(1), .REPEAT_TICKS(40)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .key_i(key_a),
        .level_o(level_a), .press_o(press_a), .release_o(release_a), .long_o(long_a)
    );

    key_debounce_multi #(
        .N_KEYS(4), .DURATION(10), .LONG_TICKS(200), .ACTIVE_HIGH(0), .REPEAT_TICKS(40)
    ) dut_n (
        .clk_i(clk), .rst_n_i(rst_n), .key_i(key_b),
        .level_o(level_b), .press_o(press_b), .release_o(release_b), .long_o(long_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_level_a"}, level_a, 4'b0000);
        chk({tag, "_press_a"}, press_a, 4'b0000);
        chk({tag, "_release_a"}, release_a, 4'b0000);
        chk({tag, "_long_a"}, long_a, 4'b0000);
        chk({tag, "_level_b"}, level_b, 4'b0000);
        chk({tag, "_press_b"}, press_b, 4'b0000);
        chk({tag, "_release_b"}, release_b, 4'b0000);
        chk({tag, "_long_b"}, long_b, 4'b0000);
    endtask

    // Watchdog: the directed sequence is far shorter than this
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] exp_press;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        key_a  = 4'b0000;
        key_b  = 4'b1111;

        // Reset state
        step();
        step();
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_quiet("post_reset");

        // 9-sample glitch on key0 is rejected
        key_a = 4'b0001;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("glitch_level", level_a, 4'b0000);
            chk("glitch_press", press_a, 4'b0000);
        end
        key_a = 4'b0000;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("glitch_after_level", level_a, 4'b0000);
        end

        // Key0 press accepted on 10th high sample
        key_a = 4'b0001;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("press_wait_level", level_a, 4'b0000);
            chk("press_wait_press", press_a, 4'b0000);
        end
        step();
        chk("press_accept_level", level_a, 4'b0001);
        chk("press_accept_press", press_a, 4'b0001);

        // Long press 200 samples after accept
        for (int i = 1; i <= 199; i++) begin
            step();
            chk("hold_long", long_a, 4'b0000);
            chk("hold_press", press_a, 4'b0000);
            chk("hold_level", level_a, 4'b0001);
        end
        step();
        chk("long_pulse", long_a, 4'b0001);
        chk("long_press", press_a, 4'b0000);

        // 100 more held samples: no further long; repeats only with the macro
        for (int i = 1; i <= 100; i++) begin
            step();
            exp_press = 4'b0000;
`ifdef KEY_DEBOUNCE_MULTI_REPEAT_EN
            if (i % 40 == 0) exp_press = 4'b0001;
`endif
            chk("after_long_long", long_a, 4'b0000);
            chk("after_long_press", press_a, exp_press);
        end

        // Release bounce: low 5, high 2, low 10
        key_a = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("bounce_low_level", level_a, 4'b0001);
            chk("bounce_low_release", release_a, 4'b0000);
        end
        key_a = 4'b0001;
        for (int i = 1; i <= 2; i++) begin
            step();
            chk("bounce_high_level", level_a, 4'b0001);
            chk("bounce_high_press", press_a, 4'b0000);
            chk("bounce_high_long", long_a, 4'b0000);
        end
        key_a = 4'b0000;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("release_wait_level", level_a, 4'b0001);
            chk("release_wait_release", release_a, 4'b0000);
        end
        step();
        chk("release_level", level_a, 4'b0000);
        chk("release_pulse", release_a, 4'b0001);
        step();
        chk("release_one_cycle", release_a, 4'b0000);

        // Active-low instance: key1 driven low for 10 samples
        key_b = 4'b1101;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("al_wait_level", level_b, 4'b0000);
        end
        step();
        chk("al_level", level_b, 4'b0010);
        chk("al_press", press_b, 4'b0010);
        chk("al_other_inst", level_a, 4'b0000);
        key_b = 4'b1111;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("al_rel_wait", release_b, 4'b0000);
        end
        step();
        chk("al_release", release_b, 4'b0010);
        chk("al_release_level", level_b, 4'b0000);

        // Reset while key2 is held at hold=150
        key_a = 4'b0100;
        for (int i = 1; i <= 10; i++) step();
        chk("k2_press", press_a, 4'b0100);
        for (int i = 1; i <= 150; i++) step();
        chk("k2_held_level", level_a, 4'b0100);
        chk("k2_held_long", long_a, 4'b0000);
        rst_n = 1'b0;
        #2;
        chk_quiet("async_reset");
        step();
        step();
        chk("reset_no_release", release_a, 4'b0000);
        chk("reset_level", level_a, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("rearm_wait_press", press_a, 4'b0000);
            chk("rearm_wait_level", level_a, 4'b0000);
        end
        step();
        chk("rearm_press", press_a, 4'b0100);
        chk("rearm_level", level_a, 4'b0100);

        // Keys 0 and 3 pressed together pulse in the same cycle
        key_a = 4'b1101;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("multi_wait_press", press_a, 4'b0000);
        end
        step();
        chk("multi_press", press_a, 4'b1001);
        chk("multi_level", level_a, 4'b1101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
